// File: rtl/mem_stage_access_unit.sv
// MEM stage: drives a req/ack data memory, stalls upstream while an access is outstanding
// and registers the MEM/WB outputs. Build macro MEM_TIMEOUT_EN adds an ack timeout (mem_err).
module mem_stage_access_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int PC_W        = 6,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] AluOutMem,
  input  logic [DATA_W-1:0] ReadData2Mem,
  input  logic [4:0]        rd_or_rt_M,
  input  logic              MemReadMem,
  input  logic              MemWriteMem,
  input  logic              RegWriteMem,
  input  logic [1:0]        MemtoRegMem,
  input  logic [PC_W-1:0]   pcPlus1Mem,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] WbData,
  output logic [4:0]        rd_W,
  output logic              RegWriteWb,
  output logic              mem_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] rdataQ;
  logic [DATA_W-1:0] wbSel;
  logic              access;
  logic              timeoutHit;
  logic              unusedBits;

  assign access = MemReadMem | MemWriteMem;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] waitCnt;

  assign timeoutHit = (waitCnt == CNT_W'(TIMEOUT_CYC - 1));
  assign unusedBits = ^AluOutMem[DATA_W-1:ADDR_W];
`else
  assign timeoutHit = 1'b0;
  assign mem_err    = 1'b0;
  assign unusedBits = (^AluOutMem[DATA_W-1:ADDR_W]) ^ (TIMEOUT_CYC < 0);
`endif

  // Stall asserts in the same cycle an access shows up so EX/MEM holds immediately
  always_comb begin
    case (state)
      IDLE:    mem_stall = access;
      REQ:     mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  always_comb begin
    case (MemtoRegMem)
      2'b01:   wbSel = rdataQ;
      2'b10:   wbSel = {{(DATA_W-PC_W){1'b0}}, pcPlus1Mem};
      default: wbSel = AluOutMem;
    endcase
  end

  // Access FSM plus MEM/WB register; a stalled edge inserts a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rdataQ     <= '0;
      WbData     <= '0;
      rd_W       <= '0;
      RegWriteWb <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      waitCnt    <= '0;
      mem_err    <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      mem_err <= 1'b0;
      if (state == REQ) begin
        waitCnt <= waitCnt + 1'b1;
      end else begin
        waitCnt <= '0;
      end
`endif
      if (mem_stall) begin
        RegWriteWb <= 1'b0;
      end else begin
        WbData     <= wbSel;
        rd_W       <= rd_or_rt_M;
        RegWriteWb <= RegWriteMem;
      end

      case (state)
        IDLE: begin
          if (access) begin
            dmem_addr  <= AluOutMem[ADDR_W-1:0];
            dmem_wdata <= ReadData2Mem;
            dmem_we    <= MemWriteMem;
            dmem_req   <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          // A late ack still beats a timeout landing on the same edge
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) begin
              rdataQ <= dmem_rdata;
            end
            state <= DONE;
          end else if (timeoutHit) begin
            dmem_req <= 1'b0;
            rdataQ   <= DATA_W'(32'hDEADBEEF);
            state    <= DONE;
`ifdef MEM_TIMEOUT_EN
            mem_err  <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Bench for mem_stage_access_unit: vector table plus reset-in-REQ and timeout sequences,
// with a scoreboard queue checked at every MEM/WB capture edge.
module tb_mem_stage_access_unit;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int PC_W   = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] AluOutMem, ReadData2Mem, dmem_wdata, dmem_rdata, WbData;
  logic [4:0]        rd_or_rt_M, rd_W;
  logic              MemReadMem, MemWriteMem, RegWriteMem, RegWriteWb;
  logic [1:0]        MemtoRegMem;
  logic [PC_W-1:0]   pcPlus1Mem;
  logic              mem_stall, dmem_req, dmem_we, dmem_ack, mem_err;
  logic [ADDR_W-1:0] dmem_addr;

  always #5 clk = ~clk;

  mem_stage_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset), .AluOutMem(AluOutMem), .ReadData2Mem(ReadData2Mem),
    .rd_or_rt_M(rd_or_rt_M), .MemReadMem(MemReadMem), .MemWriteMem(MemWriteMem),
    .RegWriteMem(RegWriteMem), .MemtoRegMem(MemtoRegMem), .pcPlus1Mem(pcPlus1Mem),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .WbData(WbData),
    .rd_W(rd_W), .RegWriteWb(RegWriteWb), .mem_err(mem_err)
  );

  typedef struct {
    logic        memRead;
    logic        memWrite;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [1:0]  sel;
    logic [5:0]  pc;
    logic [4:0]  rd;
    logic        rw;
    logic        memOn;
    int          ackWait;
    logic [31:0] rdata;
    logic [31:0] expWb;
    int          expStall;
    int          expReq;
  } vec_t;

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t        sbQ[$];
  exp_t        popped;
  vec_t        vecs[10];
  vec_t        postVecs[2];
  vec_t        toVec;
  int          checks = 0;
  int          errors = 0;
  int          stallCycles = 0, reqCycles = 0, reqStarts = 0, errCycles = 0;
  int          ackWait = 0, waitCnt = 0;
  logic        memOn = 1'b1, forceAck = 1'b0;
  logic [31:0] memRdata = '0;
  logic [7:0]  expAddr = '0;
  logic        expWe = 1'b0;
  logic [31:0] expWdata = '0;
  logic        prevReq = 1'b0, willCapture = 1'b0, stallEdge = 1'b0;
  logic        capNow, stlNow;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic setNop();
    MemReadMem = 1'b0; MemWriteMem = 1'b0; RegWriteMem = 1'b0; MemtoRegMem = 2'b00;
    AluOutMem = '0; ReadData2Mem = '0; rd_or_rt_M = '0; pcPlus1Mem = '0;
  endtask

  // Drive one instruction, hold it while stalled, then check stall/request accounting
  task automatic applyStimulus(input vec_t v);
    bit done;
    MemReadMem = v.memRead; MemWriteMem = v.memWrite; AluOutMem = v.alu;
    ReadData2Mem = v.wdata; MemtoRegMem = v.sel; pcPlus1Mem = v.pc;
    rd_or_rt_M = v.rd; RegWriteMem = v.rw;
    memOn = v.memOn; ackWait = v.ackWait; memRdata = v.rdata;
    expAddr = v.alu[7:0]; expWe = v.memWrite; expWdata = v.wdata;
    stallCycles = 0; reqCycles = 0; reqStarts = 0;
    sbQ.push_back('{v.expWb, v.rd, v.rw});
    done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(posedge clk);
      if (!stallEdge) done = 1;
    end
    if (!done) checkOutput("captureTimeout", 32'd0, 32'd1);
    #2;
    setNop();
    checkOutput("stallCycles", 32'(stallCycles), 32'(v.expStall));
    checkOutput("reqCycles", 32'(reqCycles), 32'(v.expReq));
    checkOutput("reqStarts", 32'(reqStarts), (v.expReq > 0) ? 32'd1 : 32'd0);
  endtask

  // Negedge: sample DUT state, check held request fields, and model the memory's ack
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_stall) stallCycles++;
      if (mem_err) errCycles++;
      if (dmem_req) begin
        reqCycles++;
        if (!prevReq) reqStarts++;
        checkOutput("dmemAddr", 32'(dmem_addr), 32'(expAddr));
        checkOutput("dmemWe", 32'(dmem_we), 32'(expWe));
        checkOutput("dmemWdata", dmem_wdata, expWdata);
      end
    end
    prevReq     = dmem_req;
    willCapture = !mem_stall && !reset;
    stallEdge   = mem_stall && !reset;
    dmem_ack    = forceAck;
    dmem_rdata  = ~memRdata;
    if (dmem_req && memOn && !reset) begin
      if (waitCnt == ackWait) begin
        dmem_ack   = 1'b1;
        dmem_rdata = memRdata;
        waitCnt    = 0;
      end else begin
        waitCnt++;
      end
    end else begin
      waitCnt = 0;
    end
  end

  // Capture edges pop the scoreboard; stalled edges must carry a bubble
  always @(posedge clk) begin
    capNow = willCapture;
    stlNow = stallEdge;
    #1;
    if (capNow && sbQ.size() > 0) begin
      popped = sbQ.pop_front();
      checkOutput("WbData", WbData, popped.wb);
      checkOutput("rdW", 32'(rd_W), 32'(popped.rd));
      checkOutput("RegWriteWb", 32'(RegWriteWb), 32'(popped.rw));
    end else if (stlNow) begin
      checkOutput("bubbleRegWrite", 32'(RegWriteWb), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h1234, 32'h0, 2'b00, 6'd0, 5'd5, 1'b1, 1'b1, 0, 32'h0, 32'h1234, 0, 0};
    vecs[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 2'b01, 6'd0, 5'd2, 1'b1, 1'b1, 0, 32'h0, 32'h0, 0, 0};
    vecs[2] = '{1'b1, 1'b0, 32'h42, 32'h0, 2'b01, 6'd0, 5'd7, 1'b1, 1'b1, 3, 32'hCAFEF00D, 32'hCAFEF00D, 5, 4};
    vecs[3] = '{1'b0, 1'b1, 32'h10, 32'hA5A5A5A5, 2'b00, 6'd0, 5'd0, 1'b0, 1'b1, 0, 32'h77777777, 32'h10, 2, 1};
    vecs[4] = '{1'b1, 1'b1, 32'hFFFFFF20, 32'h11112222, 2'b01, 6'd0, 5'd9, 1'b1, 1'b1, 1, 32'hBAD0BAD0, 32'hCAFEF00D, 3, 2};
    vecs[5] = '{1'b0, 1'b0, 32'h55, 32'h0, 2'b10, 6'd37, 5'd31, 1'b1, 1'b1, 0, 32'h0, 32'd37, 0, 0};
    vecs[6] = '{1'b0, 1'b0, 32'hFFFF0000, 32'h0, 2'b11, 6'd0, 5'd12, 1'b1, 1'b1, 0, 32'h0, 32'hFFFF0000, 0, 0};
    vecs[7] = '{1'b1, 1'b0, 32'h3, 32'h0, 2'b01, 6'd0, 5'd4, 1'b0, 1'b1, 0, 32'h01234567, 32'h01234567, 2, 1};
    vecs[8] = '{1'b0, 1'b0, 32'h0, 32'h0, 2'b01, 6'd0, 5'd6, 1'b1, 1'b1, 0, 32'h0, 32'h01234567, 0, 0};
    vecs[9] = '{1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 6'd63, 5'd1, 1'b0, 1'b1, 0, 32'h0, 32'd63, 0, 0};
    postVecs[0] = '{1'b0, 1'b0, 32'hBEEF, 32'h0, 2'b00, 6'd0, 5'd1, 1'b1, 1'b1, 0, 32'h0, 32'hBEEF, 0, 0};
    postVecs[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 2'b01, 6'd0, 5'd10, 1'b1, 1'b1, 0, 32'h0, 32'h0, 0, 0};
    toVec = '{1'b1, 1'b0, 32'h7, 32'h0, 2'b01, 6'd0, 5'd3, 1'b1, 1'b0, 0, 32'h0, 32'hDEADBEEF, 5, 4};

    reset = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    setNop();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstWbData", WbData, 32'h0);
    checkOutput("rstRdW", 32'(rd_W), 32'h0);
    checkOutput("rstRegWriteWb", 32'(RegWriteWb), 32'h0);
    checkOutput("rstDmemReq", 32'(dmem_req), 32'h0);
    checkOutput("rstDmemWe", 32'(dmem_we), 32'h0);
    checkOutput("rstDmemAddr", 32'(dmem_addr), 32'h0);
    checkOutput("rstDmemWdata", dmem_wdata, 32'h0);
    checkOutput("rstMemStall", 32'(mem_stall), 32'h0);
    checkOutput("rstMemErr", 32'(mem_err), 32'h0);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);
    checkOutput("memErrNeverHigh", 32'(errCycles), 32'd0);

    // Reset lands while a load sits in REQ with no ack coming
    MemReadMem = 1'b1; AluOutMem = 32'h44; MemtoRegMem = 2'b01; rd_or_rt_M = 5'd8;
    RegWriteMem = 1'b1; memOn = 1'b0; expAddr = 8'h44; expWe = 1'b0; expWdata = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    setNop();
    @(posedge clk);
    #1;
    checkOutput("midRstDmemReq", 32'(dmem_req), 32'h0);
    checkOutput("midRstRegWriteWb", 32'(RegWriteWb), 32'h0);
    checkOutput("midRstWbData", WbData, 32'h0);
    checkOutput("midRstMemStall", 32'(mem_stall), 32'h0);
    #1;
    reset = 1'b0;
    forceAck = 1'b1;
    @(posedge clk);
    #2;
    forceAck = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("strayAckDmemReq", 32'(dmem_req), 32'h0);
    checkOutput("strayAckMemStall", 32'(mem_stall), 32'h0);
    checkOutput("strayAckRegWriteWb", 32'(RegWriteWb), 32'h0);
    #1;
    memOn = 1'b1;
    for (int i = 0; i < 2; i++) applyStimulus(postVecs[i]);

`ifdef MEM_TIMEOUT_EN
    errCycles = 0;
    applyStimulus(toVec);
    repeat (2) @(posedge clk);
    checkOutput("memErrPulses", 32'(errCycles), 32'd1);
    memOn = 1'b1;
`else
    checkOutput("timeoutVecWb", toVec.expWb, 32'hDEADBEEF);
    checkOutput("memErrTied", 32'(errCycles), 32'd0);
`endif

    repeat (2) @(posedge clk);
    checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_access_unit.md
Name: mem_stage_access_unit

Overview:
- Consumer side of the EX/MEM pipeline register: reads the *Mem-suffixed control/data outputs and performs the MEM stage.
- Runs a load/store against a multi-cycle data memory over a req/ack handshake and stalls the front of the pipeline while an access is outstanding.
- Selects the write-back value and registers it into the MEM/WB stage outputs.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 8, data-memory word-address width; dmem_addr = AluOutMem[ADDR_W-1:0].
- PC_W, 6, width of the pcPlus1 field.
- TIMEOUT_CYC, 16, maximum ack wait in cycles; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- AluOutMem  in  DATA_W  address / ALU result from EX/MEM.
- ReadData2Mem  in  DATA_W  store data.
- rd_or_rt_M  in  5  destination register.
- MemReadMem  in  1  load.
- MemWriteMem  in  1  store.
- RegWriteMem  in  1  register write enable.
- MemtoRegMem  in  2  WB select: 00 ALU, 01 load data, 10 pcPlus1, 11 ALU.
- pcPlus1Mem  in  PC_W  link value.
- mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_W  word address.
- dmem_wdata  out  DATA_W  write data.
- dmem_ack  in  1  one-cycle completion pulse.
- dmem_rdata  in  DATA_W  read data, valid when dmem_ack=1.
- WbData  out  DATA_W  selected write-back value.
- rd_W  out  5  write-back register.
- RegWriteWb  out  1  write-back enable.
- mem_err  out  1  timeout pulse (0 without MEM_TIMEOUT_EN).

Behaviour:
- Reset: all outputs 0. State IDLE. Latched address/data/read-data cleared. Reset mid-access abandons the access, drops dmem_req the next cycle and issues no write-back.
- access = MemReadMem | MemWriteMem. If both are set, the write wins and the read is ignored (dmem_we=1, WbData selection unchanged).
- IDLE:
  - No access: mem_stall=0. The MEM/WB outputs capture at the edge (1-cycle latency, pass-through).
  - Access: mem_stall=1 combinationally the same cycle. At the edge, latch dmem_addr/dmem_wdata/dmem_we, set dmem_req<=1, go to REQ.
- REQ:
  - mem_stall=1. dmem_req, dmem_addr, dmem_wdata and dmem_we are held stable until dmem_ack.
  - On dmem_ack: dmem_req<=0. For a read, rdata_q<=dmem_rdata. Go to DONE.
  - dmem_ack while in IDLE or DONE is ignored.
- DONE:
  - mem_stall=0. The MEM/WB outputs capture using rdata_q; EX/MEM advances at the same edge. Go to IDLE.
  - No re-issue of the same access.
- Minimum load/store cost: 3 cycles (IDLE, REQ with same-cycle ack, DONE), giving 2 stall cycles. Each extra wait cycle adds 1.
- MEM/WB capture rule, at every edge:
  - mem_stall=0: WbData<=mux(MemtoRegMem); pcPlus1 is zero-extended to DATA_W. rd_W<=rd_or_rt_M. RegWriteWb<=RegWriteMem.
  - mem_stall=1: bubble, RegWriteWb<=0. WbData and rd_W keep their values.
- A store never writes back beyond the RegWriteMem passed in; the block does not qualify it.
- Upstream holds all EX/MEM inputs stable while mem_stall=1; the block samples them only in IDLE and at DONE.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYC, the block aborts: dmem_req<=0, mem_err pulses high for 1 cycle, rdata_q<=32'hDEADBEEF, go to DONE.
  - An ack arriving in the same cycle as the timeout wins; no error.
- MEM_TIMEOUT_EN undefined: no counter, mem_err tied 0, REQ waits indefinitely.

Test Plan:
- ALU op: AluOutMem=0x1234, MemtoRegMem=00, RegWriteMem=1, rd=5 -> next edge WbData=0x1234, rd_W=5, RegWriteWb=1, mem_stall never high.
- Load, ack after 3 wait cycles, rdata=0xCAFEF00D, addr 0x0000_0042 -> dmem_addr=0x42, dmem_req high for 4 cycles, mem_stall high 5 cycles, RegWriteWb=0 during stall, then WbData=0xCAFEF00D.
- Store addr 0x10, data 0xA5A5A5A5, ack same cycle as req -> dmem_we=1, dmem_wdata=0xA5A5A5A5, exactly one request, mem_stall high 2 cycles.
- MemRead=MemWrite=1 -> dmem_we=1, single write access. JAL-style MemtoRegMem=10, pcPlus1Mem=6'd37 -> WbData=37.
- reset asserted in REQ -> next cycle dmem_req=0, state IDLE, RegWriteWb=0. A later ack is ignored.
- With MEM_TIMEOUT_EN, TIMEOUT_CYC=4, no ack -> mem_err 1-cycle pulse after 4 REQ cycles, WbData=0xDEADBEEF for the load.
